// File: rtl/port_pkg.sv
// Shared types for the per-port ingress front end: header layout, descriptor
// struct and the ingress/egress state encodings.
package port_pkg;

    localparam int HDR_DEST = 0;
    localparam int HDR_PRIO = 4;
    localparam int HDR_LEN  = 7;
    localparam int LEN_W    = 9;

    typedef struct packed {
        logic [LEN_W-1:0] length;
        logic [2:0]       prior;
        logic [3:0]       dest;
    } hdr_t;

    typedef enum logic [1:0] {
        ING_IDLE,
        ING_HDR,
        ING_DATA,
        ING_DROP
    } ing_state_t;

    typedef enum logic [2:0] {
        EGR_IDLE,
        EGR_PRESENT,
        EGR_GAP,
        EGR_HOLD,
        EGR_LAUNCH,
        EGR_XFER
    } egr_state_t;

    function automatic hdr_t parse_hdr(input logic [15:0] w);
        hdr_t h;
        h.dest   = w[HDR_DEST +: 4];
        h.prior  = w[HDR_PRIO +: 3];
        h.length = w[HDR_LEN +: LEN_W];
        return h;
    endfunction

endpackage

// File: rtl/ingress_desc_fifo.sv
// Descriptor FIFO: one hdr_t per fully received packet, head visible
// combinationally so egress can present metadata without a read cycle.
module ingress_desc_fifo
    import port_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  hdr_t push_data,
    input  logic pop,
    output hdr_t head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wp;
    logic [PW:0] rp;
    hdr_t        mem [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign head  = mem[rp[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/port_ingress.sv
// Per-port ingress: parses the header, stores a whole packet in a local word
// buffer, then presents metadata and bursts the payload to the controller.
module port_ingress
    import port_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BUF_DEPTH  = 512,
    parameter int DESC_DEPTH = 8,
    parameter int ALMOST_TH  = 64,
    parameter int STOP_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_sop,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_eop,
    output logic              full,
    output logic              almost_full,
    output logic [2:0]        prior,
    output logic [3:0]        dest_port,
    output logic [8:0]        length,
    output logic              writting,
    output logic              new_packet,
    output logic              data_vld,
    output logic [DATA_W-1:0] data,
    output logic              xfer_en,
    input  logic              xfer_stop,
    output logic              xfer_stop_out
);

    // Egress handshake: new_packet marks one metadata cycle; xfer_stop seen in
    // that cycle or the next defers the packet, otherwise xfer_en commits it and
    // data_vld then stays high for exactly length cycles with no backpressure.

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int SW = $clog2(STOP_CYC + 1);
    localparam logic [AW:0] BUF_WORDS = BUF_DEPTH[AW:0];

    ing_state_t ing_state, ing_next;
    egr_state_t egr_state, egr_next;

    logic [AW:0]       wr_ptr, sh_ptr, rel_ptr, free_words;
    logic [LEN_W-1:0]  cnt, rd_idx;
    logic [AW-1:0]     rd_addr;
    logic [SW-1:0]     stop_cnt;
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [DATA_W-1:0] rd_q;
    hdr_t              in_hdr, cur_hdr, head;
    logic err, hdr_ok, hdr_take, buf_we, over, commit;
    logic desc_full, desc_empty, pop, rd_en, stop_seen, egr_busy;

    assign in_hdr     = parse_hdr(wr_data[15:0]);
    assign free_words = BUF_WORDS - (wr_ptr - rel_ptr);
    assign hdr_ok     = (in_hdr.length != '0) && !desc_full &&
                        (int'(in_hdr.length) <= int'(free_words));

    ingress_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc (
        .clk       (clk),
        .rst       (rst),
        .push      (commit),
        .push_data (cur_hdr),
        .pop       (pop),
        .head      (head),
        .full      (desc_full),
        .empty     (desc_empty)
    );

    // ---------------- ingress FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) ing_state <= ING_IDLE;
        else     ing_state <= ing_next;
    end

    // wr_eop is resolved before a same-cycle wr_sop restarts header parsing.
    always_comb begin
        ing_next = ing_state;
        case (ing_state)
            ING_IDLE: if (wr_sop) ing_next = ING_HDR;
            ING_HDR: begin
                if (wr_sop)      ing_next = ING_HDR;
                else if (wr_eop) ing_next = ING_IDLE;
                else if (wr_vld) ing_next = hdr_ok ? ING_DATA : ING_DROP;
            end
            ING_DATA, ING_DROP: begin
                if (wr_sop)      ing_next = ING_HDR;
                else if (wr_eop) ing_next = ING_IDLE;
            end
            default: ing_next = ING_IDLE;
        endcase
    end

    always_comb begin
        hdr_take = 1'b0;
        buf_we   = 1'b0;
        over     = 1'b0;
        commit   = 1'b0;
        case (ing_state)
            ING_HDR: hdr_take = wr_vld && !wr_sop && !wr_eop && hdr_ok;
            ING_DATA: begin
                buf_we = wr_vld && !wr_sop && (cnt != cur_hdr.length);
                over   = wr_vld && !wr_sop && (cnt == cur_hdr.length);
                commit = wr_eop && !err && (cnt == cur_hdr.length);
            end
            default: ;
        endcase
    end

    // Payload lands at the shadow pointer; only a clean eop publishes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            sh_ptr  <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            cur_hdr <= '0;
        end else begin
            if (hdr_take) begin
                cur_hdr <= in_hdr;
                sh_ptr  <= wr_ptr;
                cnt     <= '0;
                err     <= 1'b0;
            end
            if (buf_we) begin
                sh_ptr <= sh_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            if (over)   err    <= 1'b1;
            if (commit) wr_ptr <= sh_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) mem[sh_ptr[AW-1:0]] <= wr_data;
        if (rd_en)  rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            full        <= desc_full || (free_words == '0);
            almost_full <= int'(free_words) < ALMOST_TH;
        end
    end

    // ---------------- egress FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) egr_state <= EGR_IDLE;
        else     egr_state <= egr_next;
    end

    always_comb begin
        egr_next = egr_state;
        case (egr_state)
            EGR_IDLE:    if (!desc_empty) egr_next = EGR_PRESENT;
            EGR_PRESENT: egr_next = EGR_GAP;
            EGR_GAP:     egr_next = (stop_seen || xfer_stop) ? EGR_HOLD : EGR_LAUNCH;
            EGR_HOLD:    if (stop_cnt == SW'(STOP_CYC - 1)) egr_next = EGR_PRESENT;
            EGR_LAUNCH:  egr_next = EGR_XFER;
            EGR_XFER:    if (rd_idx == head.length) egr_next = EGR_IDLE;
            default:     egr_next = EGR_IDLE;
        endcase
    end

    // rd_idx runs one word ahead of the word on data because the read is registered.
    always_comb begin
        egr_busy      = (egr_state != EGR_IDLE);
        new_packet    = (egr_state == EGR_PRESENT);
        xfer_en       = (egr_state == EGR_LAUNCH) || (egr_state == EGR_XFER);
        data_vld      = (egr_state == EGR_XFER);
        xfer_stop_out = (egr_state == EGR_HOLD) && (stop_cnt == SW'(STOP_CYC - 1));
        rd_en         = xfer_en;
        pop           = data_vld && (rd_idx == head.length);
        rd_addr       = rel_ptr[AW-1:0] + AW'(rd_idx);
        prior         = egr_busy ? head.prior  : '0;
        dest_port     = egr_busy ? head.dest   : '0;
        length        = egr_busy ? head.length : '0;
        data          = data_vld ? rd_q : '0;
    end

    assign writting = !desc_empty || egr_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            rel_ptr   <= '0;
            rd_idx    <= '0;
            stop_cnt  <= '0;
            stop_seen <= 1'b0;
        end else begin
            case (egr_state)
                EGR_PRESENT: begin
                    stop_seen <= xfer_stop;
                    stop_cnt  <= '0;
                    rd_idx    <= '0;
                end
                EGR_HOLD:             stop_cnt <= stop_cnt + 1'b1;
                EGR_LAUNCH, EGR_XFER: rd_idx   <= rd_idx + 1'b1;
                default: ;
            endcase
            if (pop) rel_ptr <= rel_ptr + (AW+1)'(head.length);
        end
    end

endmodule

// File: doc/port_ingress.md
Name: port_ingress

Overview:
- Per-port ingress front end; 16 instances sit directly upstream of the switch controller, one per input port.
- Accepts the raw wr_sop/wr_vld/wr_data/wr_eop packet stream and parses the header word.
- Buffers the whole packet in a local word FIFO and only then offers it to the controller.
- The controller sees packet metadata first, can hold the port off with xfer_stop, then receives the payload as a gap-free data_vld burst.

Parameters:
- DATA_W, 16, data word width.
- BUF_DEPTH, 512, payload buffer depth in words (power of 2).
- DESC_DEPTH, 8, packet descriptor FIFO depth (power of 2).
- ALMOST_TH, 64, free-word threshold for almost_full.
- STOP_CYC, 16, cycles held in HOLD before re-presenting a stopped packet.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- wr_sop  in  1  start-of-packet pulse, one cycle, wr_vld low.
- wr_vld  in  1  wr_data valid.
- wr_data  in  DATA_W  first valid word is the header, the rest is payload.
- wr_eop  in  1  end-of-packet pulse, one cycle after the last payload word, wr_vld low.
- full  out  1  registered; descriptor FIFO full or 0 free words.
- almost_full  out  1  registered; free words < ALMOST_TH.
- prior  out  3  head packet priority.
- dest_port  out  4  head packet destination.
- length  out  9  head packet payload length in words.
- writting  out  1  a packet is buffered or in transfer.
- new_packet  out  1  one-cycle pulse; head metadata is being presented.
- data_vld  out  1  payload word valid on data.
- data  out  DATA_W  payload word.
- xfer_en  out  1  transfer of the head packet is committed.
- xfer_stop  in  1  controller refuses the presented packet.
- xfer_stop_out  out  1  one-cycle pulse; stop honoured, packet about to be re-presented.

Behaviour:
- Header word fields: dest = [3:0], prior = [6:4], length = [15:7].
- Reset values:
  - All outputs are 0.
  - Both FIFOs are empty; all pointers are 0.
  - Both FSMs are in IDLE.
  - Reset mid-packet discards everything with no commit.
- Ingress FSM:
  - States: IDLE, HDR, DATA, DROP.
  - IDLE: on wr_sop go to HDR.
  - HDR, on wr_vld:
    - If length == 0, or length > free words, or the descriptor FIFO is full: go to DROP.
    - Otherwise latch the descriptor, set the shadow write pointer = committed write pointer, go to DATA.
  - DATA:
    - Each wr_vld writes the buffer at the shadow pointer and increments cnt.
    - A word beyond length is ignored and flags an error.
    - On wr_eop with cnt == length and no error: commit the shadow pointer and push the descriptor.
    - On wr_eop otherwise: roll back. Either way, go to IDLE.
  - DROP: ignore everything until wr_eop, then go to IDLE.
  - wr_sop in HDR/DATA/DROP: abandon the current packet (rollback), go to HDR.
  - wr_sop and wr_eop in the same cycle: wr_eop is processed first, then the new packet starts.
- Free words = BUF_DEPTH − (committed write pointer − release pointer), modulo 2·BUF_DEPTH with a one-extra-bit pointer scheme; pointers wrap naturally.
- Egress FSM:
  - States: IDLE, PRESENT, GAP, HOLD, LAUNCH, XFER.
  - IDLE → PRESENT when the descriptor FIFO is non-empty.
  - PRESENT: new_packet = 1 for 1 cycle; prior/dest_port/length driven from the head and stable until XFER ends.
  - GAP: 1 cycle.
    - xfer_stop sampled high in PRESENT or GAP → HOLD.
    - Otherwise → LAUNCH.
  - HOLD:
    - Count STOP_CYC cycles, then pulse xfer_stop_out and go to PRESENT.
    - If xfer_stop is still high at re-present, the packet is held again.
  - LAUNCH: xfer_en = 1, data_vld = 0, 1 cycle.
  - XFER:
    - xfer_en = 1 and data_vld = 1 for exactly length consecutive cycles, reading the buffer at the read pointer.
    - Buffer read is registered; the read for word 0 is issued in LAUNCH.
    - xfer_stop is ignored here.
  - After the last word: pop the descriptor, release pointer += length, go to IDLE.
  - Back-to-back packets: next PRESENT 1 cycle after the last data_vld.
- writting = 1 whenever the descriptor FIFO is non-empty or the egress FSM is not in IDLE.
- Simultaneous ingress push and egress pop are both applied. Freed space becomes visible to the HDR check the cycle after the release.

Decomposition:
- Shared package port_pkg:
  - hdr_t struct {length[8:0], prior[2:0], dest[3:0]}.
  - Ingress and egress state enums.
  - HDR_DEST/HDR_PRIO/HDR_LEN bit-position constants.
- One sub-module: ingress_desc_fifo, a synchronous DESC_DEPTH × hdr_t FIFO with push/pop/full/empty.
- Payload buffer is an inferred RAM inside port_ingress.

Test Plan:
- Send header 0x0183 (dest 3, prior 0, length 3) + 3 words 0xA,0xB,0xC, then eop → new_packet pulse with dest_port=3, length=3; GAP; LAUNCH xfer_en=1; data_vld for 3 cycles carrying 0xA,0xB,0xC; writting then drops to 0.
- Same packet with xfer_stop=1 held for 5 cycles from PRESENT → HOLD; xfer_stop_out pulses after 16 cycles; new_packet repeats; then a normal burst of 3 words.
- Header length 4 but only 2 payload words, then eop → no descriptor, free words unchanged (512), no new_packet.
- Fill the buffer: length 511 packet committed, then a length-2 packet arrives → dropped; almost_full=1; after egress drains, a length-2 packet is accepted and the pointers wrap past 512 with correct data.
- wr_sop mid-payload, then a valid 1-word packet → only the 1-word packet is emitted.
- Assert rst for 1 cycle during XFER word 2 of 5 → all outputs 0 the next cycle; no further data_vld.
